// File: rtl/marked_replay_fifo_if.sv
// marked_replay_fifo_if: data, command and status bundle of the replay FIFO.
// master drives writes/reads/commands; slave is the FIFO itself.
interface marked_replay_fifo_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 9
);
    logic [WIDTH-1:0]    wdata;
    logic                write;
    logic                full;
    logic                read;
    logic [WIDTH-1:0]    rdata;
    logic                rvalid;
    logic                emptyB;
    logic                mark;
    logic                replay;
    logic [DEPTH_LOG2:0] count;
    logic                overflow;
    logic                underflow;

    modport master (
        output wdata, write, read, mark, replay,
        input  full, rdata, rvalid, emptyB, count, overflow, underflow
    );

    modport slave (
        input  wdata, write, read, mark, replay,
        output full, rdata, rvalid, emptyB, count, overflow, underflow
    );
endinterface

// File: rtl/marked_replay_fifo.sv
// marked_replay_fifo: character FIFO with a protected replay region,
// explicit mark, sticky error flags and a registered read strobe.
module marked_replay_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 erase,
    marked_replay_fifo_if.slave  bus
);
    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0]    wrptr_q, wrptr_d;
    logic [PW-1:0]    rdptr_q, rdptr_d;
    logic [PW-1:0]    rpptr_q, rpptr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             clr;
    logic             full;
    logic             empty_b;
    logic             wr_acc;
    logic             rd_acc;
    logic [PW-1:0]    used;

    // Status from registered pointers; replay blocks the read handshake.
    always_comb begin
        clr     = reset | erase;
        used    = wrptr_q - rpptr_q;
        full    = (used == CAP);
        empty_b = (rdptr_q != wrptr_q);
        wr_acc  = bus.write & ~full;
        rd_acc  = bus.read & empty_b & ~bus.replay;
    end

    assign bus.full      = full;
    assign bus.emptyB    = empty_b;
    assign bus.count     = wrptr_q - rdptr_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    // Write port of the simple dual-port RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !clr) begin
            mem[wrptr_q[DEPTH_LOG2-1:0]] <= bus.wdata;
        end
    end

    // Next state: pointers, read register and sticky flags.
    always_comb begin
        wrptr_d     = wrptr_q;
        rdptr_d     = rdptr_q;
        rpptr_d     = rpptr_q;
        rdata_d     = rdata_q;
        rvalid_d    = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (wr_acc) begin
            wrptr_d = wrptr_q + PW'(1);
        end
        if (bus.write && full) begin
            overflow_d = 1'b1;
        end

        if (bus.replay) begin
            rdptr_d = rpptr_q;
        end else if (rd_acc) begin
            rdptr_d  = rdptr_q + PW'(1);
            rdata_d  = mem[rdptr_q[DEPTH_LOG2-1:0]];
            rvalid_d = 1'b1;
        end else if (bus.read) begin
            underflow_d = 1'b1;
        end

        // A write into a drained buffer starts a new message, dropping
        // the old protected data unless the consumer is marking now.
        if (bus.replay) begin
            rpptr_d = rpptr_q;
        end else if (bus.mark) begin
            rpptr_d = rdptr_q;
        end else if (wr_acc && !empty_b) begin
            rpptr_d = wrptr_q;
        end

        if (clr) begin
            wrptr_d     = '0;
            rdptr_d     = '0;
            rpptr_d     = '0;
            rdata_d     = '0;
            rvalid_d    = 1'b0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    // State register; clearing is folded into the next-state logic.
    always_ff @(posedge clk) begin
        wrptr_q     <= wrptr_d;
        rdptr_q     <= rdptr_d;
        rpptr_q     <= rpptr_d;
        rdata_q     <= rdata_d;
        rvalid_q    <= rvalid_d;
        overflow_q  <= overflow_d;
        underflow_q <= underflow_d;
    end
endmodule
